spi_slave_rx_mode0: RTL and testbench
=====================================

# spi_slave_rx_mode0

SPI mode-0 receive front end that consumes the SCLK/SS/MOSI lines driven by our SPI master and reconstructs bytes in the system `clk` domain. It synchronizes the three lines, detects SCLK rising edges while SS is low, and shifts MOSI in MSB-first. It delivers complete bytes with a valid strobe and flags aborted frames. It is the downstream partner of the master in the loopback lab setup, and a reusable slave-side receiver.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on SCLK/SS/MOSI; legal values are ≥ 2.
- `clk` input 1: system clock, the same domain as the master.
- `rst` input 1: reset, asynchronous, active-high.
- `SCLK` input 1: SPI clock from the master; idles low.
- `SS` input 1: slave select, active-low.
- `MOSI` input 1: serial data, MSB first.
- `rx_data` output 8: received byte.
- `rx_valid` output 1: byte available.
- `rx_ready` input 1: consumer accepts the byte. Used only with the FIFO option.
- `frame_err` output 1: one-cycle pulse when SS deasserts mid-byte.
- `rx_overflow` output 1: one-cycle pulse when a byte is dropped.
- `busy` output 1: high while the FSM is in SHIFT.

## Operation
- **Synchronization.** SCLK, SS and MOSI each pass through `SYNC_STAGES` flops. Edge detect compares the last synchronized stage with one further register (`sclk_d`).
  - MOSI is taken from the same stage as the SCLK edge.
  - The master changes MOSI on the same clk edge that raises SCLK, so the sampled MOSI is the new bit.
- **FSM states: IDLE, SHIFT.**
  - IDLE → SHIFT when synchronized SS is low. `bit_cnt` = 0.
  - In SHIFT, each synchronized SCLK rising edge does `shift = {shift[6:0], mosi_s}` and `bit_cnt++`. The 3-bit counter wraps.
  - On the 8th edge (`bit_cnt` == 7 → 0), the byte `{shift[6:0], mosi_s}` is delivered. The FSM stays in SHIFT, so further clocks with SS low start the next byte.
  - SHIFT → IDLE when synchronized SS goes high.
    - If `bit_cnt` ≠ 0, `frame_err` pulses and the partial byte is discarded.
    - If `bit_cnt` = 0, there is no error.
- SCLK activity while SS is high is ignored. `bit_cnt` and `shift` hold.
- If SS rises on the same cycle as the 8th SCLK edge, the byte is delivered and no error is raised.
- **Reset values:** all synchronizer flops 0, except the SS chain, which resets to 1. `rx_data` = 0x00, `rx_valid` = 0, `frame_err` = 0, `rx_overflow` = 0, `busy` = 0, FSM = IDLE, `bit_cnt` = 0.
- **Reset mid-byte** discards the partial byte and empties the FIFO. After release, the FSM re-enters SHIFT only via a synchronized SS low, with `bit_cnt` = 0.

## Timing
- `rx_valid` and `rx_data` are registered. The delivery cycle is `SYNC_STAGES`+1 clk cycles after the clk edge on which raw SCLK makes its 8th rise.
- The master toggles SCLK every clk cycle, so each SCLK level lasts at least 1 clk. The detector handles this minimum without missing edges.
- `frame_err` asserts on the cycle the FSM leaves SHIFT: `SYNC_STAGES`+1 cycles after raw SS rises.
- Without the FIFO, `rx_valid` is a one-cycle pulse and `rx_data` holds until the next byte.

## Configuration
- Macro: `SPI_RX_FIFO_EN`.
- **Defined:** a 4-entry FIFO sits between the shifter and the outputs.
  - `rx_valid` = FIFO not empty; `rx_data` = head entry, combinationally from registered storage.
  - Pop on `rx_valid && rx_ready`.
  - A byte delivered while the FIFO holds 4 entries is dropped and `rx_overflow` pulses. This applies even if a pop occurs in the same cycle, so the full check uses pre-pop occupancy.
  - Simultaneous push and pop at non-full occupancy keeps the count unchanged.
- **Undefined:** no storage; `rx_ready` is ignored; `rx_overflow` is tied 0.

## Structure
- Shared package `spi_pkg` holds:
  - `SPI_BYTE_W` = 8
  - `SPI_RX_FIFO_DEPTH` = 4
  - the FSM state encoding: IDLE = 1'b0, SHIFT = 1'b1
- Sub-module `spi_rx_fifo`: synchronous FIFO with depth and width from `spi_pkg`, 2-bit read/write pointers and a 3-bit count. It is instantiated only under `SPI_RX_FIFO_EN`.

## Test plan
- **Single byte:** master sends 0xA5 → exactly one `rx_valid` with `rx_data` = 0xA5 at the specified latency; `frame_err` stays 0.
- **Back-to-back:** master frames 0x00, 0xFF, 0x3C → three valid bytes received in order; `busy` drops between frames.
- **Abort:** SS pulled high after 3 SCLK rises → `frame_err` pulse; no `rx_valid`. A following 0x81 is received correctly.
- **Noise while deselected:** SCLK toggles 20 times with SS high → no `rx_valid`, no `frame_err`, `busy` = 0.
- **FIFO option** (`SPI_RX_FIFO_EN`):
  - 5 bytes 0x01–0x05 with `rx_ready` = 0 → 4 stored and `rx_overflow` pulses on 0x05.
  - Then `rx_ready` = 1 → pops 0x01–0x04 in order and `rx_valid` drops.
- **Reset mid-byte:** `rst` pulsed after 4 bits → all outputs at reset values. The next full frame 0x5A is received as 0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared byte width, receive FIFO depth and receiver FSM
//               state encoding for the SPI slave receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W        = 8;
    localparam int SPI_RX_FIFO_DEPTH = 4;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : 4-entry synchronous byte FIFO. Overflow is judged on the
//               occupancy before any same-cycle pop.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [SPI_BYTE_W-1:0] i_data,
    input  logic                  i_pop,
    output logic [SPI_BYTE_W-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_overflow
);

    logic [SPI_BYTE_W-1:0] r_mem [SPI_RX_FIFO_DEPTH];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic                  r_overflow;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == 3'(SPI_RX_FIFO_DEPTH));
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && (r_count != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SPI_RX_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_push && w_full;
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_empty    = (r_count == 3'd0);
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx_mode0.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx_mode0
// Description : SPI mode-0 slave receiver; synchronizes SCLK/SS/MOSI into
//               clk, shifts MSB-first and delivers bytes. Optional 4-entry
//               output FIFO when SPI_RX_FIFO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx_mode0
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  rx_overflow,
    output logic                  busy
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;

    logic [0:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [SPI_BYTE_W-1:0] r_shift;
    logic                  r_frame_err;

    logic                  w_sclk_s;
    logic                  w_ss_s;
    logic                  w_mosi_s;
    logic                  w_sclk_rise;
    logic [0:0]            w_state_nxt;
    logic [2:0]            w_bit_cnt_nxt;
    logic [SPI_BYTE_W-1:0] w_shift_nxt;
    logic [SPI_BYTE_W-1:0] w_byte;
    logic                  w_deliver;
    logic                  w_frame_err;

    // SS chain resets high so the receiver starts deselected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s && !r_sclk_d;
    assign w_byte      = {r_shift[SPI_BYTE_W-2:0], w_mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_frame_err;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_deliver     = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!w_ss_s) begin
                    w_state_nxt   = c_SHIFT;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            c_SHIFT: begin
                if (w_sclk_rise) begin
                    w_shift_nxt   = w_byte;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    w_deliver     = (r_bit_cnt == 3'd7);
                end
                // A byte completing on the deselect cycle is not an abort.
                if (w_ss_s) begin
                    w_state_nxt = c_IDLE;
                    w_frame_err = (r_bit_cnt != 3'd0) && !w_deliver;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign frame_err = r_frame_err;
    assign busy      = (r_state == c_SHIFT);

`ifdef SPI_RX_FIFO_EN
    logic w_fifo_empty;

    spi_rx_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_deliver),
        .i_data     (w_byte),
        .i_pop      (rx_valid && rx_ready),
        .o_data     (rx_data),
        .o_empty    (w_fifo_empty),
        .o_overflow (rx_overflow)
    );

    assign rx_valid = !w_fifo_empty;
`else
    logic [SPI_BYTE_W-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  w_unused_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_deliver;
            if (w_deliver) begin
                r_rx_data <= w_byte;
            end
        end
    end

    assign rx_data        = r_rx_data;
    assign rx_valid       = r_rx_valid;
    assign rx_overflow    = 1'b0;
    assign w_unused_ready = rx_ready;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx_mode0.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx_mode0
// Description : Self-checking bench for spi_slave_rx_mode0 (set
//               SPI_RX_FIFO_EN to cover the FIFO build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx_mode0;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       SS = 1'b1;
    logic       MOSI = 1'b0;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_overflow;
    logic       busy;

    spi_slave_rx_mode0 #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .SCLK        (SCLK),
        .SS          (SS),
        .MOSI        (MOSI),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .rx_overflow (rx_overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         exp_valid;
        int         exp_ferr;
    } frame_t;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_ferr = 0;
    int   n_ovf = 0;
    int   last_ferr_cyc = -1;
    rec_t exp_q[$];
    rec_t obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: record every accepted byte and count error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid && rx_ready) obs_q.push_back('{rx_data, cyc});
            if (frame_err) begin
                n_ferr        <= n_ferr + 1;
                last_ferr_cyc <= cyc;
            end
            if (rx_overflow) n_ovf <= n_ovf + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master-style bit clocking: MOSI changes with SCLK rise, one clk per level.
    // mode 0 = no expectation, 1 = expect with latency, 2 = expect, latency unchecked.
    task automatic send_bits(input logic [7:0] d, input int n, input int mode, input bit ss_on_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MOSI = d[7-i];
            SCLK = 1'b1;
            if (ss_on_last && i == n - 1) SS = 1'b1;
            if (i == 7 && mode != 0) exp_q.push_back('{d, (mode == 1) ? cyc + S + 1 : -1});
            @(posedge clk); #1;
            SCLK = 1'b0;
        end
    endtask

    // Compare observed bytes against the scoreboard, then require both drained.
    task automatic drain(input string name);
        rec_t e, o;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                check({name, "_unexpected_byte"}, int'(o.data), -1);
            end else begin
                e = exp_q.pop_front();
                check({name, "_data"}, int'(o.data), int'(e.data));
                if (e.cyc >= 0) check({name, "_latency"}, o.cyc, e.cyc);
            end
        end
        check({name, "_missing_bytes"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    frame_t tbl[6];

    initial begin
        int f0, ss_cyc;
        tbl[0] = '{8'hA5, 8, 1, 0};
        tbl[1] = '{8'h00, 8, 1, 0};
        tbl[2] = '{8'hFF, 8, 1, 0};
        tbl[3] = '{8'h3C, 8, 1, 0};
        tbl[4] = '{8'hE7, 3, 0, 1};
        tbl[5] = '{8'h81, 8, 1, 0};

        wait_cycles(3);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_rx_overflow", int'(rx_overflow), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        wait_cycles(3);

        // Separate frames, including one aborted after three bits.
        foreach (tbl[k]) begin
            f0 = n_ferr;
            SS = 1'b0;
            wait_cycles(S + 2);
            send_bits(tbl[k].data, tbl[k].nbits, tbl[k].exp_valid, 1'b0);
            check($sformatf("busy_in_frame%0d", k), int'(busy), 1);
            SS = 1'b1;
            ss_cyc = cyc;
            wait_cycles(S + 4);
            check($sformatf("busy_after_frame%0d", k), int'(busy), 0);
            check($sformatf("frame_err_count%0d", k), n_ferr - f0, tbl[k].exp_ferr);
            if (tbl[k].exp_ferr != 0) check("frame_err_timing", last_ferr_cyc, ss_cyc + S + 1);
            drain($sformatf("frame%0d", k));
        end

        // Two bytes in one selection, no gap.
        f0 = n_ferr;
        SS = 1'b0;
        wait_cycles(S + 2);
        send_bits(8'hC3, 8, 1, 1'b0);
        send_bits(8'h5E, 8, 1, 1'b0);
        SS = 1'b1;
        wait_cycles(S + 4);
        check("b2b_frame_err", n_ferr - f0, 0);
        drain("b2b");

        // SS rising together with the eighth SCLK rise still delivers.
        f0 = n_ferr;
        SS = 1'b0;
        wait_cycles(S + 2);
        send_bits(8'h96, 8, 1, 1'b1);
        wait_cycles(S + 4);
        check("ss_with_8th_edge_frame_err", n_ferr - f0, 0);
        check("ss_with_8th_edge_busy", int'(busy), 0);
        drain("ss_with_8th_edge");

        // Clock noise while deselected.
        f0 = n_ferr;
        send_bits(8'hA5, 8, 0, 1'b0);
        send_bits(8'hFF, 8, 0, 1'b0);
        send_bits(8'h0F, 4, 0, 1'b0);
        wait_cycles(S + 4);
        check("noise_frame_err", n_ferr - f0, 0);
        check("noise_busy", int'(busy), 0);
        drain("noise");

`ifdef SPI_RX_FIFO_EN
        // Five bytes into a stalled consumer: fifth overflows.
        rx_ready = 1'b0;
        SS = 1'b0;
        wait_cycles(S + 2);
        for (int b = 1; b <= 4; b++) send_bits(8'(b), 8, 2, 1'b0);
        wait_cycles(S + 3);
        check("fifo_no_overflow_at_4", n_ovf, 0);
        send_bits(8'h05, 8, 0, 1'b0);
        SS = 1'b1;
        wait_cycles(S + 4);
        check("fifo_overflow_count", n_ovf, 1);
        check("fifo_valid_held", int'(rx_valid), 1);
        check("fifo_head", int'(rx_data), 1);
        rx_ready = 1'b1;
        wait_cycles(8);
        check("fifo_valid_after_drain", int'(rx_valid), 0);
        drain("fifo");
`endif

        // Reset in the middle of a byte.
        f0 = n_ferr;
        SS = 1'b0;
        wait_cycles(S + 2);
        send_bits(8'hF0, 4, 0, 1'b0);
        #2;
        rst = 1'b1;
        SS = 1'b1;
        #2;
        check("midrst_rx_data", int'(rx_data), 0);
        check("midrst_rx_valid", int'(rx_valid), 0);
        check("midrst_frame_err", int'(frame_err), 0);
        check("midrst_rx_overflow", int'(rx_overflow), 0);
        check("midrst_busy", int'(busy), 0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3);
        SS = 1'b0;
        wait_cycles(S + 2);
        send_bits(8'h5A, 8, 1, 1'b0);
        SS = 1'b1;
        wait_cycles(S + 4);
        check("midrst_no_frame_err", n_ferr - f0, 0);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
